// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster dot/line timing generator with a frame-aligned
// capture window sequencer (IDLE -> ARM -> ACTIVE -> DONE).
// Optional feature macro: ODD_FRAME_SKIP_EN. When defined, the last dot of
// odd frames is dropped while render_en is high.
module video_timing_ctrl #(
    parameter int IMAGE_W         = 256,
    parameter int IMAGE_H         = 240,
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       render_en,
    input  logic       capture_req,
    input  logic       capture_abort,
    input  logic [7:0] capture_frames,
    output logic [8:0] dot,
    output logic [8:0] line,
    output logic [7:0] pixel_x,
    output logic [7:0] pixel_y,
    output logic       pixel_en,
    output logic       frame,
    output logic       vblank,
    output logic       odd_frame,
    output logic       capture_busy,
    output logic       capture_pixel_en,
    output logic       capture_done
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VB_LINE   = 9'(VBLANK_LINE);
    localparam logic [8:0] PIX_W     = 9'(IMAGE_W);
    localparam logic [8:0] PIX_H     = 9'(IMAGE_H);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic       skip;
    logic       line_end;
    logic       frame_end;
    logic [1:0] state;
    logic [7:0] remaining;

`ifdef ODD_FRAME_SKIP_EN
    localparam logic [8:0] DOT_SKIP = 9'(DOTS_PER_LINE - 2);
    // Odd rendered frames end one dot early.
    assign skip = odd_frame & render_en & (line == LINE_LAST) & (dot == DOT_SKIP);
`else
    logic unused_render;
    assign unused_render = render_en;
    assign skip          = 1'b0;
`endif

    assign line_end  = skip | (dot == DOT_LAST);
    assign frame_end = line_end & (line == LINE_LAST);

    // Raster counters; frame pulse and parity are registered off the wrap so
    // they line up with the cycle showing dot 0 / line 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot       <= 9'd0;
            line      <= 9'd0;
            frame     <= 1'b0;
            odd_frame <= 1'b0;
            vblank    <= 1'b0;
        end else begin
            frame <= frame_end;
            if (line_end) begin
                dot  <= 9'd0;
                line <= (line == LINE_LAST) ? 9'd0 : line + 9'd1;
            end else begin
                dot <= dot + 9'd1;
            end
            if (frame_end)
                odd_frame <= ~odd_frame;
            // Decided at dot 0 so the flag changes in the dot 1 cycle.
            if (dot == 9'd0 && line == VB_LINE)
                vblank <= 1'b1;
            else if (dot == 9'd0 && line == LINE_LAST)
                vblank <= 1'b0;
        end
    end

    // Visible window decode.
    always_comb begin
        pixel_en = (dot != 9'd0) && (dot <= PIX_W) && (line < PIX_H);
        pixel_x  = pixel_en ? 8'(dot - 9'd1) : 8'd0;
        pixel_y  = pixel_en ? line[7:0] : 8'd0;
    end

    // Capture sequencer: arm on request, run whole frames, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A frame pulse here is deliberately not looked at.
                    if (capture_req && !capture_abort) begin
                        state     <= S_ARM;
                        remaining <= (capture_frames == 8'd0) ? 8'd1 : capture_frames;
                    end
                end
                S_ARM: begin
                    if (capture_abort)
                        state <= S_IDLE;
                    else if (frame)
                        state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (capture_abort)
                        state <= S_IDLE;
                    else if (frame) begin
                        if (remaining == 8'd1)
                            state <= S_DONE;
                        else
                            remaining <= remaining - 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        capture_busy     = (state == S_ARM) || (state == S_ACTIVE);
        capture_pixel_en = pixel_en && (state == S_ACTIVE);
        capture_done     = (state == S_DONE);
    end

endmodule
